data_read_capture_fifo: RTL and testbench

Capture buffer for the data_read pcore: samples an external parallel data word on each valid strobe, stores it in a small first-word-fall-through FIFO, and presents the head word plus status to the AXI-lite read slave on the same clock. The slave pops one word per RDATA read and reads the level and sticky overflow flag. A programmable-threshold interrupt flags when enough data is buffered.

---
 rtl/data_read_capture_fifo.sv | 96 +++++++++
 tb/tb_data_read_capture_fifo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/data_read_capture_fifo.sv
// data_read_capture_fifo: first-word-fall-through capture buffer between an
// external parallel data source and the AXI-lite read slave. Holds up to
// 2^DEPTH_LOG2 words and provides level, a sticky overflow flag and a
// threshold interrupt.
module data_read_capture_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  cap_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    input  logic                  flush,
    output logic                  ovf,
    input  logic                  ovf_clr,
    input  logic [DEPTH_LOG2:0]   thresh,
    output logic                  irq
);

    localparam int unsigned         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  push;
    logic                  pop;
    logic                  wr_accept;
    logic                  drop;

    // Status comes only from the count register, never from the strobes.
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign level   = count;
    assign rd_data = mem[rd_ptr];

    // Accept/drop decisions and next word count; flush overrides everything.
    always_comb begin
        push       = cap_en & din_valid;
        pop        = rd_en & ~empty;
        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        wr_accept  = push & (~full | pop);
        drop       = push & full & ~pop;
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (wr_accept && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !wr_accept) begin
            count_next = count - 1'b1;
        end
    end

    // Storage array: written only on an accepted push outside a flush.
    always_ff @(posedge S_AXI_ACLK) begin
        if (wr_accept && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, count, sticky overflow and registered threshold interrupt.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            irq    <= 1'b0;
        end else begin
            count <= count_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_accept) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            // Set wins over clear; a flush suppresses the set but keeps the flag.
            ovf <= (drop & ~flush) | (ovf & ~ovf_clr);
            irq <= (count_next >= thresh) && (thresh != '0);
        end
    end

endmodule

// File: tb/tb_data_read_capture_fifo.sv
// Directed, table-driven bench for data_read_capture_fifo.
module tb_data_read_capture_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cap_en = 1'b0;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0;
    logic        rd_en = 1'b0;
    logic        flush = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [4:0]  thresh = '0;
    logic [31:0] rd_data;
    logic        empty;
    logic        full;
    logic [4:0]  level;
    logic        ovf;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_read_capture_fifo #(
        .DATA_WIDTH(32),
        .DEPTH_LOG2(4)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .cap_en       (cap_en),
        .din          (din),
        .din_valid    (din_valid),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .level        (level),
        .flush        (flush),
        .ovf          (ovf),
        .ovf_clr      (ovf_clr),
        .thresh       (thresh),
        .irq          (irq)
    );

    typedef struct {
        string       name;
        logic        ce;
        logic        dv;
        logic [31:0] d;
        logic        re;
        logic        fl;
        logic        oc;
        logic [4:0]  th;
        int          e_level;
        logic        e_ovf;
        logic        e_irq;
        logic        chk_data;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string nm, logic ce, logic dv, logic [31:0] d,
                                logic re, logic fl, logic oc, logic [4:0] th,
                                int el, logic eo, logic ei, logic cd,
                                logic [31:0] ed);
        vec_t v;
        v.name = nm; v.ce = ce; v.dv = dv; v.d = d; v.re = re; v.fl = fl;
        v.oc = oc; v.th = th; v.e_level = el; v.e_ovf = eo; v.e_irq = ei;
        v.chk_data = cd; v.e_data = ed;
        vecs.push_back(v);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_status(string nm, int el, logic eo, logic ei);
        chk({nm, " level"}, 32'(level), el);
        chk({nm, " empty"}, 32'(empty), 32'(el == 0));
        chk({nm, " full"},  32'(full),  32'(el == 16));
        chk({nm, " ovf"},   32'(ovf),   32'(eo));
        chk({nm, " irq"},   32'(irq),   32'(ei));
    endtask

    task automatic run_table();
        foreach (vecs[i]) begin
            cap_en = vecs[i].ce; din_valid = vecs[i].dv; din = vecs[i].d;
            rd_en = vecs[i].re; flush = vecs[i].fl; ovf_clr = vecs[i].oc;
            thresh = vecs[i].th;
            @(posedge clk);
            #1;
            check_status(vecs[i].name, vecs[i].e_level, vecs[i].e_ovf, vecs[i].e_irq);
            if (vecs[i].chk_data) chk({vecs[i].name, " rd_data"}, rd_data, vecs[i].e_data);
        end
        vecs.delete();
        cap_en = 0; din_valid = 0; rd_en = 0; flush = 0; ovf_clr = 0;
    endtask

    initial begin
        // Reset state, before and after release.
        #3;
        check_status("reset_held", 0, 0, 0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_status("after_release", 0, 0, 0);

        // First pass fill, overflow handling, simultaneous push/pop, drain.
        for (int i = 0; i < 16; i++)
            add($sformatf("fill1_%0d", i), 1, 1, 32'h1000 + i, 0, 0, 0, 0, i + 1, 0, 0, 1, 32'h1000);
        add("ovf_drop",     1, 1, 32'hDEAD, 0, 0, 0, 0, 16, 1, 0, 1, 32'h1000);
        add("ovf_clr_drop", 1, 1, 32'hDEAD, 0, 0, 1, 0, 16, 1, 0, 1, 32'h1000);
        add("ovf_clr",      0, 0, 32'h0,    0, 0, 1, 0, 16, 0, 0, 1, 32'h1000);
        add("sim_full",     1, 1, 32'hBEEF, 1, 0, 0, 0, 16, 0, 0, 1, 32'h1001);
        for (int k = 0; k < 16; k++)
            add($sformatf("drain1_%0d", k), 0, 0, 32'h0, 1, 0, 0, 0, 15 - k, 0, 0,
                logic'(k < 15), (k < 14) ? 32'h1002 + k : 32'hBEEF);
        add("pop_empty", 0, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);

        // Second pass after pointer wrap, overflow left set across drain and flush.
        for (int i = 0; i < 16; i++)
            add($sformatf("fill2_%0d", i), 1, 1, 32'h2000 + i, 0, 0, 0, 0, i + 1, 0, 0, 1, 32'h2000);
        add("ovf_drop2", 1, 1, 32'hDEAD, 0, 0, 0, 0, 16, 1, 0, 1, 32'h2000);
        for (int k = 0; k < 16; k++)
            add($sformatf("drain2_%0d", k), 0, 0, 32'h0, 1, 0, 0, 0, 15 - k, 1, 0,
                logic'(k < 15), 32'h2001 + k);
        for (int i = 0; i < 7; i++)
            add($sformatf("fill3_%0d", i), 1, 1, 32'h4000 + i, 0, 0, 0, 0, i + 1, 1, 0, 1, 32'h4000);
        add("flush_push_pop", 1, 1, 32'h4007, 1, 1, 0, 0, 0, 1, 0, 0, 32'h0);
        add("ovf_clr2",       0, 0, 32'h0,    0, 0, 1, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 10; i++)
            add($sformatf("cap_off_%0d", i), 0, 1, 32'h7000 + i, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        run_table();

        // Threshold interrupt at 4.
        for (int i = 0; i < 4; i++)
            add($sformatf("thr_push_%0d", i), 1, 1, 32'h5000 + i, 0, 0, 0, 4, i + 1, 0,
                logic'(i == 3), 1, 32'h5000);
        add("thr_pop0", 0, 0, 32'h0, 1, 0, 0, 4, 3, 0, 0, 1, 32'h5001);
        add("thr_pop1", 0, 0, 32'h0, 1, 0, 0, 4, 2, 0, 0, 1, 32'h5002);
        add("thr_pop2", 0, 0, 32'h0, 1, 0, 0, 4, 1, 0, 0, 1, 32'h5003);
        add("thr_pop3", 0, 0, 32'h0, 1, 0, 0, 4, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 5; i++)
            add($sformatf("pre_rst_%0d", i), 1, 1, 32'h6000 + i, 0, 0, 0, 4, i + 1, 0,
                logic'(i >= 3), 1, 32'h6000);
        run_table();

        // Asynchronous reset mid-fill at level 5, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_status("async_rst", 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        add("post_rst_push", 1, 1, 32'h3000, 0, 0, 0, 4, 1, 0, 0, 1, 32'h3000);
        add("post_rst_pop",  0, 0, 32'h0,    1, 0, 0, 4, 0, 0, 0, 0, 32'h0);
        run_table();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
